shift_register_sequencer: RTL and testbench
===========================================

Name: shift_register_sequencer

Overview:
- FSM controller for the team's 4-bit universal shift register (s: 00 hold, 01 shift toward MSB, 10 shift toward LSB, 11 parallel load).
- Accepts one command at a time (load, shift-up, shift-down, rotate) through a valid/ready handshake.
- Drives the register's select, serial and parallel inputs for the required number of cycles, then pulses done.
- Sits between a host/test sequencer and one shift register instance; both run on the same clk and clear_b.

Parameters:
WIDTH, 4, register width; parallel data and rotate feedback width
CNT_W, 3, width of shift-count field (max count 2^CNT_W-1 = 7)

Ports:
clk  in  1  system clock, rising edge
clear_b  in  1  asynchronous active-low reset; shared with the shift register it controls
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  2  00 LOAD, 01 SHUP (bit0<=fill, bit i<=bit i-1), 10 SHDN (bit3<=fill, bit i<=bit i+1), 11 ROT (SHUP with bit0<=bit3)
cmd_count  in  CNT_W  number of shift cycles; ignored for LOAD
cmd_data  in  WIDTH  parallel load value for LOAD
cmd_fill  in  1  serial fill bit for SHUP/SHDN
sr_s  out  2  select to shift register
sr_serial_in_r  out  1  serial input entering bit0 (s=01)
sr_serial_in_l  out  1  serial input entering bit3 (s=10)
sr_parallel_in  out  WIDTH  parallel load data (s=11)
sr_parallel_out  in  WIDTH  register contents, used for ROT feedback
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on command completion

Behaviour:
- Reset (clear_b=0, asynchronous): state=IDLE, latched op/count/data/fill=0, sr_s=00, sr_serial_in_r=0, sr_serial_in_l=0, sr_parallel_in=0, busy=0, done=0, cmd_ready=1.
- States:
  - IDLE: cmd_ready=1, sr_s=00.
  - LOAD: sr_s=11, sr_parallel_in=latched data; exactly 1 cycle, then DONE.
  - SHIFT: sr_s=01 (SHUP/ROT) or 10 (SHDN); remaining count decrements each cycle; leaves after the cycle where remaining=1.
  - DONE: sr_s=00, done=1 for 1 cycle, then IDLE.
- Accept: on a rising edge with IDLE && cmd_valid, latch op, count, data and fill.
  - LOAD goes to LOAD.
  - Shift ops with count≠0 go to SHIFT with remaining=count.
  - Shift ops with count=0 go directly to DONE; the register sees no non-hold select.
- Outputs are Moore-decoded from state and latched fields. The register updates on the edge ending each LOAD/SHIFT cycle.
- Latency from accept edge to done high:
  - LOAD: 2 cycles.
  - Shift: count+1 cycles.
  - Register contents are final when done is high.
- Serial inputs during SHIFT:
  - SHUP: sr_serial_in_r=fill.
  - SHDN: sr_serial_in_l=fill.
  - ROT: sr_serial_in_r=sr_parallel_out[WIDTH-1], a combinational path from the register output.
  - Unused serial input is driven 0. Outside SHIFT both are 0.
- sr_parallel_in is 0 outside LOAD.
- cmd_valid while busy is ignored, with no queueing. The host must hold cmd_valid until it sees cmd_ready on the same edge.
- Back-to-back commands: the next command can be accepted on the edge after DONE, i.e. when IDLE is re-entered.
- Reset mid-operation: immediately IDLE with sr_s=00, no done pulse. The shift register is cleared by the same reset.
- Count arithmetic is unsigned CNT_W bits; no wrap past 0.

Test Plan:
- Reset then LOAD data=1011 -> cmd_ready=1 pre-accept; sr_s=11 for 1 cycle; sr_parallel_out=1011 and done=1 two cycles after accept; sr_s=00 thereafter.
- From 1011, SHUP count=2 fill=1 -> sr_s=01 for exactly 2 cycles; register 0111, then 1111; done on cycle 3; busy high cycles 1-3.
- From 1011, SHDN count=1 fill=0 -> sr_s=10 for 1 cycle; register 0101; done 2 cycles after accept.
- From 1011, ROT count=1 -> 0111; ROT count=4 from 1011 -> 1011 with done 5 cycles after accept; sr_serial_in_r tracks bit3 each cycle.
- SHUP count=0 -> done 1 cycle after accept; sr_s never leaves 00; register unchanged.
- Assert cmd_valid with a second command during SHIFT -> ignored, cmd_ready=0. Pull clear_b low mid-SHIFT (count=7) -> sr_s=00, busy=0, done=0 immediately; register 0000; the next command is accepted normally.

Source files
------------

// File: rtl/shift_register_sequencer_if.sv
// shift_register_sequencer_if: host-side command handshake and status bundle.
interface shift_register_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic             busy;
    logic             done;
    modport master (output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, input cmd_ready, busy, done);
    modport slave  (input cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, output cmd_ready, busy, done);
endinterface

// File: rtl/shift_register_sequencer.sv
// shift_register_sequencer: sequences load/shift/rotate commands onto a 4-bit universal shift register.
module shift_register_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                      clk,
    input  logic                      clear_b,
    shift_register_sequencer_if.slave cmd_if,
    output logic [1:0]                sr_s,
    output logic                      sr_serial_in_r,
    output logic                      sr_serial_in_l,
    output logic [WIDTH-1:0]          sr_parallel_in,
    input  logic [WIDTH-1:0]          sr_parallel_out
);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHUP = 2'b01;
    localparam logic [1:0] OP_SHDN = 2'b10;
    localparam logic [1:0] OP_ROT  = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_fill;
    logic             w_accept;
    logic             w_shift;
    logic             w_unused;

    assign w_accept = r_state == IDLE && cmd_if.cmd_valid;
    assign w_shift  = r_state == SHIFT;
    // only the MSB is fed back (ROT); the rest of the register output is not needed here
    assign w_unused = &{1'b0, sr_parallel_out[WIDTH-2:0]};

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_fill  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= cmd_if.cmd_op;
                r_cnt  <= cmd_if.cmd_count;
                r_data <= cmd_if.cmd_data;
                r_fill <= cmd_if.cmd_fill;
            end else if (w_shift) begin
                r_cnt  <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = w_accept ? (cmd_if.cmd_op == OP_LOAD ? LOAD : cmd_if.cmd_count != '0 ? SHIFT : DONE)
               : r_state == LOAD  ? DONE
               : r_state == SHIFT ? (r_cnt == CNT_W'(1) ? DONE : SHIFT)
               : r_state == DONE  ? IDLE
               : r_state;
    end

    assign cmd_if.cmd_ready = r_state == IDLE;
    assign cmd_if.busy      = r_state != IDLE;
    assign cmd_if.done      = r_state == DONE;
    assign sr_s             = r_state == LOAD ? 2'b11 : w_shift ? (r_op == OP_SHDN ? 2'b10 : 2'b01) : 2'b00;
    assign sr_parallel_in   = r_state == LOAD ? r_data : '0;
    // ROT feeds the current MSB straight back into bit0 within the same cycle
    assign sr_serial_in_r   = !w_shift ? 1'b0 : r_op == OP_SHUP ? r_fill : r_op == OP_ROT ? sr_parallel_out[WIDTH-1] : 1'b0;
    assign sr_serial_in_l   = w_shift && r_op == OP_SHDN && r_fill;
endmodule

// File: tb/tb_shift_register_sequencer.sv
// tb_shift_register_sequencer: directed vector table plus hand-written corner sequences against a shift register plant.
module tb_shift_register_sequencer;
    logic       clk = 1'b0;
    logic       clear_b = 1'b0;
    logic [1:0] sr_s;
    logic       sr_serial_in_r, sr_serial_in_l;
    logic [3:0] sr_parallel_in, q;
    int         checks = 0;
    int         failures = 0;

    shift_register_sequencer_if #(.WIDTH(4), .CNT_W(3)) cif ();

    shift_register_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .clear_b(clear_b), .cmd_if(cif.slave),
        .sr_s(sr_s), .sr_serial_in_r(sr_serial_in_r), .sr_serial_in_l(sr_serial_in_l),
        .sr_parallel_in(sr_parallel_in), .sr_parallel_out(q)
    );

    // the universal shift register being controlled
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) q <= 4'b0;
        else if (sr_s == 2'b01) q <= {q[2:0], sr_serial_in_r};
        else if (sr_s == 2'b10) q <= {sr_serial_in_l, q[3:1]};
        else if (sr_s == 2'b11) q <= sr_parallel_in;
    end

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pre;
        logic [1:0] op;
        logic [2:0] cnt;
        logic [3:0] data;
        logic       fill;
        logic [3:0] exp_q;
        int         exp_lat;
        int         exp_nh;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] d, input logic f,
                           output int lat, output int nh, output int bc);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_count = cnt;
        cif.cmd_data  = d;
        cif.cmd_fill  = f;
        step();
        cif.cmd_valid = 1'b0;
        lat = 1;
        nh  = 0;
        bc  = 0;
        while (!cif.done && lat < 20) begin
            if (sr_s != 2'b00) nh++;
            if (cif.busy) bc++;
            step();
            lat++;
        end
        if (cif.busy) bc++;
    endtask

    initial begin
        int lat, nh, bc;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_count = 3'd0;
        cif.cmd_data  = 4'd0;
        cif.cmd_fill  = 1'b0;
        vecs[0] = '{4'b0000, 2'b00, 3'd0, 4'b1011, 1'b0, 4'b1011, 2, 1};
        vecs[1] = '{4'b1011, 2'b01, 3'd2, 4'b0000, 1'b1, 4'b1111, 3, 2};
        vecs[2] = '{4'b1011, 2'b10, 3'd1, 4'b0000, 1'b0, 4'b0101, 2, 1};
        vecs[3] = '{4'b1011, 2'b11, 3'd1, 4'b0000, 1'b0, 4'b0111, 2, 1};
        vecs[4] = '{4'b1011, 2'b11, 3'd4, 4'b0000, 1'b0, 4'b1011, 5, 4};
        vecs[5] = '{4'b1011, 2'b01, 3'd0, 4'b0000, 1'b1, 4'b1011, 1, 0};
        vecs[6] = '{4'b0110, 2'b10, 3'd3, 4'b0000, 1'b1, 4'b1110, 4, 3};
        vecs[7] = '{4'b1001, 2'b01, 3'd7, 4'b0000, 1'b0, 4'b0000, 8, 7};
        vecs[8] = '{4'b1000, 2'b11, 3'd2, 4'b0000, 1'b0, 4'b0010, 3, 2};
        vecs[9] = '{4'b0101, 2'b10, 3'd0, 4'b1111, 1'b1, 4'b0101, 1, 0};

        step();
        chk("rst_ready", int'(cif.cmd_ready), 1);
        chk("rst_busy", int'(cif.busy), 0);
        chk("rst_done", int'(cif.done), 0);
        chk("rst_sr_s", int'(sr_s), 0);
        chk("rst_serial", int'({sr_serial_in_r, sr_serial_in_l}), 0);
        chk("rst_pin", int'(sr_parallel_in), 0);
        clear_b = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_cmd(2'b00, 3'd0, vecs[i].pre, 1'b0, lat, nh, bc);
            step();
            chk($sformatf("v%0d_ready", i), int'(cif.cmd_ready), 1);
            run_cmd(vecs[i].op, vecs[i].cnt, vecs[i].data, vecs[i].fill, lat, nh, bc);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_q", i), int'(q), int'(vecs[i].exp_q));
            chk($sformatf("v%0d_nonhold", i), nh, vecs[i].exp_nh);
            chk($sformatf("v%0d_busy", i), bc, vecs[i].exp_lat);
            chk($sformatf("v%0d_done_sr_s", i), int'(sr_s), 0);
            step();
            chk($sformatf("v%0d_done_pulse", i), int'(cif.done), 0);
            chk($sformatf("v%0d_idle", i), int'(cif.cmd_ready), 1);
        end

        // ROT 4 from 1011: serial_in_r must follow the live MSB 1,0,1,1
        run_cmd(2'b00, 3'd0, 4'b1011, 1'b0, lat, nh, bc);
        step();
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b11;
        cif.cmd_count = 3'd4;
        step();
        cif.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_bits;
            exp_bits = 4'b1101;
            chk($sformatf("rot_sr_s%0d", k), int'(sr_s), 1);
            chk($sformatf("rot_sin_r%0d", k), int'(sr_serial_in_r), int'(exp_bits[k]));
            chk($sformatf("rot_sin_l%0d", k), int'(sr_serial_in_l), 0);
            chk($sformatf("rot_pin%0d", k), int'(sr_parallel_in), 0);
            step();
        end
        chk("rot_done", int'(cif.done), 1);
        chk("rot_q", int'(q), 4'b1011);
        step();

        // command offered during SHIFT is ignored
        run_cmd(2'b00, 3'd0, 4'b0000, 1'b0, lat, nh, bc);
        step();
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b01;
        cif.cmd_count = 3'd3;
        cif.cmd_fill  = 1'b1;
        step();
        cif.cmd_op    = 2'b00;
        cif.cmd_data  = 4'b1111;
        chk("ign_ready0", int'(cif.cmd_ready), 0);
        step();
        chk("ign_ready1", int'(cif.cmd_ready), 0);
        chk("ign_sr_s", int'(sr_s), 1);
        cif.cmd_valid = 1'b0;
        step();
        step();
        chk("ign_done", int'(cif.done), 1);
        chk("ign_q", int'(q), 4'b0111);
        step();
        step();
        chk("ign_no_load", int'(q), 4'b0111);
        chk("ign_idle_sr_s", int'(sr_s), 0);

        // reset in the middle of a long shift
        run_cmd(2'b00, 3'd0, 4'b1011, 1'b0, lat, nh, bc);
        step();
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b01;
        cif.cmd_count = 3'd7;
        cif.cmd_fill  = 1'b1;
        step();
        cif.cmd_valid = 1'b0;
        step();
        step();
        chk("mid_busy_pre", int'(cif.busy), 1);
        clear_b = 1'b0;
        #1;
        chk("mid_sr_s", int'(sr_s), 0);
        chk("mid_busy", int'(cif.busy), 0);
        chk("mid_done", int'(cif.done), 0);
        chk("mid_q", int'(q), 0);
        chk("mid_ready", int'(cif.cmd_ready), 1);
        step();
        clear_b = 1'b1;
        step();
        chk("post_rst_done", int'(cif.done), 0);
        run_cmd(2'b00, 3'd0, 4'b0110, 1'b0, lat, nh, bc);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_q", int'(q), 4'b0110);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
